acc_fifo: RTL and testbench

ACC_FIFO -- requirements
Module: acc_fifo

---
 rtl/acc_fifo.sv | 110 +++++++++++
 tb/tb_acc_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/acc_fifo.sv
// acc_fifo: single-clock FIFO with registered read data and exact flags.
// Ports: clk, reset, put_req/data_in (write), get_req/data_out (read),
// empty, full; with ACC_FIFO_STATUS_EN also count, overflow, underflow.
module acc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             put_req,
  input  logic [WIDTH-1:0] data_in,
  input  logic             get_req,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
`ifdef ACC_FIFO_STATUS_EN
  ,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             put_ok, get_ok;

  // When full, a concurrent get frees the slot the put lands in:
  // wr_ptr == rd_ptr, and the read samples the old word on the same edge.
  assign get_ok = get_req & ~empty_q & ~reset;
  assign put_ok = put_req & (~full_q | get_req) & ~reset;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    if (put_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (get_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem[rd_ptr_q];
    end
    if (put_ok && !get_ok)
      cnt_d = cnt_q + (AW+1)'(1);
    else if (!put_ok && get_ok)
      cnt_d = cnt_q - (AW+1)'(1);
    // Flags from the next count so they land on the same edge.
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (put_ok) mem[wr_ptr_q] <= data_in;
  end

  assign data_out = dout_q;
  assign empty    = empty_q;
  assign full     = full_q;

`ifdef ACC_FIFO_STATUS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (put_req & ~put_ok & ~reset);
    udf_d = udf_q | (get_req & ~get_ok & ~reset);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign count     = cnt_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_acc_fifo.sv
// tb_acc_fifo: directed test of acc_fifo with a read-data scoreboard.
module tb_acc_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             reset;
  logic             put_req;
  logic [WIDTH-1:0] data_in;
  logic             get_req;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
`ifdef ACC_FIFO_STATUS_EN
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;
`endif

  acc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .put_req  (put_req),
    .data_in  (data_in),
    .get_req  (get_req),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
`ifdef ACC_FIFO_STATUS_EN
    ,
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] mlast;
  int               tok_issued = 0;
  int               tok_done = 0;
  logic             movf, mudf;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic monitor();
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (tok_done < tok_issued) begin
        tok_done++;
        if (exp_q.size() == 0) begin
          check("sb_underrun", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_data", data_out, e);
        end
      end
    end
  endtask

  task automatic check_state(input string nm);
    check({nm, "_empty"}, 32'(empty), 32'(mq.size() == 0));
    check({nm, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
`ifdef ACC_FIFO_STATUS_EN
    check({nm, "_count"}, 32'(count), 32'(mq.size()));
    check({nm, "_ovf"}, 32'(overflow), 32'(movf));
    check({nm, "_udf"}, 32'(underflow), 32'(mudf));
`endif
  endtask

  task automatic cyc(input logic p, input logic [WIDTH-1:0] d,
                     input logic g);
    logic pa, ga;
    @(negedge clk);
    put_req = p;
    data_in = d;
    get_req = g;
    ga = g && (mq.size() > 0);
    pa = p && ((mq.size() < DEPTH) || g);
    @(posedge clk);
    if (p && !pa) movf = 1'b1;
    if (g && !ga) mudf = 1'b1;
    if (ga) begin
      mlast = mq.pop_front();
      exp_q.push_back(mlast);
    end
    if (pa) mq.push_back(d);
    #1;
    if (ga) tok_issued++;
    else check("hold_dout", data_out, mlast);
    check_state("cyc");
  endtask

  task automatic do_reset();
    @(negedge clk);
    put_req = 1'b0;
    get_req = 1'b0;
    #2;
    reset = 1'b1;
    mq.delete();
    mlast = '0;
    movf = 1'b0;
    mudf = 1'b0;
    #1;
    check("rst_dout", data_out, 32'h0);
    check_state("rst");
    put_req = 1'b1;
    data_in = 32'hBAD0BAD0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    put_req = 1'b0;
    #1;
    check_state("rst_rel");
  endtask

  initial begin
    reset   = 1'b1;
    put_req = 1'b0;
    get_req = 1'b0;
    data_in = '0;
    mlast   = '0;
    movf    = 1'b0;
    mudf    = 1'b0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
      end
    join_none
    #1;
    check("por_dout", data_out, 32'h0);
    check_state("por");
    do_reset();

    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1'b0);
    cyc(1'b1, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("after_drop_get", data_out, 32'h10);

    do_reset();
    cyc(1'b1, 32'hA5A5A5A5, 1'b1);
    check("ep_dout0", data_out, 32'h0);
    cyc(1'b0, '0, 1'b1);

    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h100 + 32'(i), 1'b0);
    cyc(1'b1, 32'h55, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b0, '0, 1'b1);
    check("last_55", data_out, 32'h55);

    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, 32'h300 + 32'(i), 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, '0, 1'b1);

    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h400 + 32'(i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    do_reset();
    cyc(1'b1, 32'h77, 1'b0);
    cyc(1'b0, '0, 1'b1);

    repeat (3) @(negedge clk);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    check("sb_tokens", 32'(tok_done), 32'(tok_issued));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
